// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC bus read/write control slice.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } pic_state_e;

  localparam logic RSEL_IRR = 1'b0;
  localparam logic RSEL_ISR = 1'b1;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ADI  = 2;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_ID   = 4;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_SFNM = 4;

  localparam int OCW_KIND_HI = 4;
  localparam int OCW_KIND_LO = 3;
  localparam logic [1:0] OCW_KIND_OCW2 = 2'b00;
  localparam logic [1:0] OCW_KIND_OCW3 = 2'b01;
  localparam int OCW3_RR  = 1;
  localparam int OCW3_RIS = 0;

endpackage

// File: rtl/pic_strobe_sync.sv
// Multi-flop synchroniser for one bus pin with rise/fall detection on the synchronised copy.
module pic_strobe_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= {STAGES{RST_VAL}};
      q_d <= RST_VAL;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      q_d <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/pic_bus_rw_ctrl.sv
// CPU-side register access, init-sequence FSM and INTA vector sequencing for the PIC.
// state        | meaning
// ST_UNINIT    | no ICW1 seen since reset
// ST_WAIT_ICW2 | ICW1 taken, next a0=1 write is the vector base
// ST_WAIT_ICW3 | cascade mask / slave id expected
// ST_WAIT_ICW4 | mode word expected
// ST_READY     | initialised; OCWs, masks and INTA active
module pic_bus_rw_ctrl
  import pic_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             a0,
  input  logic [7:0]       d_in,
  output logic [7:0]       d_out,
  output logic             d_oe,
  input  logic             inta_n,
  input  logic [N_IRQ-1:0] irr,
  input  logic [N_IRQ-1:0] isr,
  input  logic [2:0]       irq_id,
  output logic             init_done,
  output logic             ltim,
  output logic             sngl,
  output logic             adi,
  output logic [7:0]       vec_hi,
  output logic [7:0]       icw3,
  output logic             upm,
  output logic             aeoi,
  output logic             sfnm,
  output logic [N_IRQ-1:0] imr,
  output logic             ocw2_stb,
  output logic [7:0]       ocw2,
  output logic             inta_first,
  output logic             inta_last
);

  logic cs_s, rd_s, wr_s, inta_s, a0_s;
  logic rd_rise, rd_fall, wr_rise, wr_fall, inta_rise, inta_fall;
  logic cs_rise, cs_fall, a0_rise, a0_fall;
  logic unused_sync;

  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .din(rd_n), .q(rd_s), .rise(rd_rise), .fall(rd_fall));
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .din(wr_n), .q(wr_s), .rise(wr_rise), .fall(wr_fall));
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_inta (
    .clk(clk), .rst_n(rst_n), .din(inta_n), .q(inta_s), .rise(inta_rise), .fall(inta_fall));
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_a0 (
    .clk(clk), .rst_n(rst_n), .din(a0), .q(a0_s), .rise(a0_rise), .fall(a0_fall));

  assign unused_sync = ^{cs_rise, cs_fall, a0_rise, a0_fall, inta_s};

  pic_state_e state_q, state_d;

  logic       illegal;
  logic       wr_cs_n_q, wr_a0_q, wr_bad_q;
  logic [7:0] wr_d_q;
  logic       commit, is_icw1, is_data, is_ocw2, is_ocw3;
  logic       ic4_q, rsel_q;
  logic [2:0] a75_q;

  assign illegal = ~cs_s & ~rd_s & ~wr_s;

  // Write address/data are frozen at the falling edge; overlap with a read poisons the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cs_n_q <= 1'b1;
      wr_a0_q   <= 1'b0;
      wr_d_q    <= 8'h00;
      wr_bad_q  <= 1'b0;
    end else if (wr_fall) begin
      wr_cs_n_q <= cs_s;
      wr_a0_q   <= a0_s;
      wr_d_q    <= d_in;
      wr_bad_q  <= ~cs_s & ~rd_s;
    end else if (illegal) begin
      wr_bad_q  <= 1'b1;
    end
  end

  assign commit  = wr_rise & ~wr_cs_n_q & ~wr_bad_q;
  assign is_icw1 = commit & ~wr_a0_q & wr_d_q[ICW1_ID];
  assign is_data = commit & wr_a0_q;
  assign is_ocw2 = commit & ~wr_a0_q & (state_q == ST_READY) &
                   (wr_d_q[OCW_KIND_HI:OCW_KIND_LO] == OCW_KIND_OCW2);
  assign is_ocw3 = commit & ~wr_a0_q & (state_q == ST_READY) &
                   (wr_d_q[OCW_KIND_HI:OCW_KIND_LO] == OCW_KIND_OCW3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_UNINIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_icw1) begin
      state_d = ST_WAIT_ICW2;
    end else if (is_data) begin
      case (state_q)
        ST_WAIT_ICW2: state_d = !sngl ? ST_WAIT_ICW3 : (ic4_q ? ST_WAIT_ICW4 : ST_READY);
        ST_WAIT_ICW3: state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
        ST_WAIT_ICW4: state_d = ST_READY;
        default:      state_d = state_q;
      endcase
    end
  end

  assign init_done = (state_q == ST_READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ltim     <= 1'b0;
      sngl     <= 1'b0;
      adi      <= 1'b0;
      ic4_q    <= 1'b0;
      a75_q    <= 3'b000;
      vec_hi   <= 8'h00;
      icw3     <= 8'h00;
      upm      <= 1'b0;
      aeoi     <= 1'b0;
      sfnm     <= 1'b0;
      imr      <= '0;
      rsel_q   <= RSEL_IRR;
      ocw2     <= 8'h00;
      ocw2_stb <= 1'b0;
    end else begin
      ocw2_stb <= is_ocw2;
      if (is_icw1) begin
        ltim   <= wr_d_q[ICW1_LTIM];
        sngl   <= wr_d_q[ICW1_SNGL];
        adi    <= wr_d_q[ICW1_ADI];
        ic4_q  <= wr_d_q[ICW1_IC4];
        a75_q  <= wr_d_q[7:5];
        imr    <= '0;
        icw3   <= 8'h00;
        upm    <= 1'b0;
        aeoi   <= 1'b0;
        sfnm   <= 1'b0;
        rsel_q <= RSEL_IRR;
      end else if (is_data) begin
        case (state_q)
          ST_WAIT_ICW2: vec_hi <= wr_d_q;
          ST_WAIT_ICW3: icw3   <= wr_d_q;
          ST_WAIT_ICW4: begin
            upm  <= wr_d_q[ICW4_UPM];
            aeoi <= wr_d_q[ICW4_AEOI];
            sfnm <= wr_d_q[ICW4_SFNM];
          end
          ST_READY:     imr <= wr_d_q[N_IRQ-1:0];
          default:      ;
        endcase
      end else if (is_ocw2) begin
        ocw2 <= wr_d_q;
      end else if (is_ocw3 && wr_d_q[OCW3_RR]) begin
        rsel_q <= wr_d_q[OCW3_RIS];
      end
    end
  end

  logic [1:0] inta_cnt;
  logic       inta_act, inta_drv;
  logic [2:0] irq_hold;
  logic [7:0] inta_byte;
  logic       inta_byte_drv;
  logic       inta_start;
  logic       rd_act;
  logic [7:0] rd_byte;

  assign inta_start = inta_fall & init_done & ~inta_act & ~is_icw1;

  // Pulse index inta_cnt selects which vector byte goes out on this falling edge.
  always_comb begin
    inta_byte     = 8'h00;
    inta_byte_drv = 1'b0;
    if (upm) begin
      if (inta_cnt == 2'd1) begin
        inta_byte     = {vec_hi[7:3], irq_hold};
        inta_byte_drv = 1'b1;
      end
    end else begin
      inta_byte_drv = 1'b1;
      case (inta_cnt)
        2'd0:    inta_byte = CALL_OPCODE;
        2'd1:    inta_byte = adi ? {a75_q, irq_hold, 2'b00} : {a75_q[2:1], irq_hold, 3'b000};
        default: inta_byte = vec_hi;
      endcase
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    if (a0_s)                   rd_byte = 8'(imr);
    else if (rsel_q == RSEL_ISR) rd_byte = 8'(isr);
    else                        rd_byte = 8'(irr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_cnt   <= 2'd0;
      inta_act   <= 1'b0;
      inta_drv   <= 1'b0;
      irq_hold   <= 3'd0;
      inta_first <= 1'b0;
      inta_last  <= 1'b0;
      rd_act     <= 1'b0;
      d_out      <= 8'h00;
    end else begin
      inta_first <= 1'b0;
      inta_last  <= 1'b0;
      if (is_icw1) begin
        inta_cnt <= 2'd0;
        inta_act <= 1'b0;
        inta_drv <= 1'b0;
      end else if (inta_start) begin
        inta_act <= 1'b1;
        inta_drv <= inta_byte_drv;
        if (inta_byte_drv) d_out <= inta_byte;
        if (inta_cnt == 2'd0) begin
          inta_first <= 1'b1;
          irq_hold   <= irq_id;
        end
      end else if (inta_rise && inta_act) begin
        inta_act <= 1'b0;
        inta_drv <= 1'b0;
        if (inta_cnt == (upm ? 2'd1 : 2'd2)) begin
          inta_cnt  <= 2'd0;
          inta_last <= 1'b1;
        end else begin
          inta_cnt <= inta_cnt + 2'd1;
        end
      end

      if (rd_fall && !cs_s) begin
        rd_act <= 1'b1;
        if (!inta_act && !inta_start) d_out <= rd_byte;
      end else if (rd_rise) begin
        rd_act <= 1'b0;
      end
    end
  end

  assign d_oe = inta_act ? inta_drv : (rd_act & ~illegal);

endmodule

// File: tb/tb_pic_bus_rw_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random traffic vs model.
module tb_pic_bus_rw_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic [7:0] irr = 8'h00, isr = 8'h00;
  logic [2:0] irq_id = 3'd0;
  logic [7:0] d_out, vec_hi, icw3, ocw2, imr;
  logic       d_oe, init_done, ltim, sngl, adi, upm, aeoi, sfnm, ocw2_stb, inta_first, inta_last;

  pic_bus_rw_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .inta_n(inta_n), .irr(irr), .isr(isr),
    .irq_id(irq_id), .init_done(init_done), .ltim(ltim), .sngl(sngl), .adi(adi),
    .vec_hi(vec_hi), .icw3(icw3), .upm(upm), .aeoi(aeoi), .sfnm(sfnm), .imr(imr),
    .ocw2_stb(ocw2_stb), .ocw2(ocw2), .inta_first(inta_first), .inta_last(inta_last));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int first_cnt = 0, last_cnt = 0, stb_cnt = 0;

  always @(negedge clk) begin
    if (inta_first) first_cnt++;
    if (inta_last)  last_cnt++;
    if (ocw2_stb)   stb_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    cs_n = 1'b0; a0 = a; d_in = d;
    tick(1);
    wr_n = 1'b0;
    tick(5);
    wr_n = 1'b1;
    tick(5);
    cs_n = 1'b1;
    tick(2);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] v, output logic oe, output logic oe_after);
    cs_n = 1'b0; a0 = a;
    tick(1);
    rd_n = 1'b0;
    tick(5);
    @(negedge clk);
    v = d_out; oe = d_oe;
    tick(2);
    if (d_out !== v) oe = 1'bx;
    rd_n = 1'b1;
    tick(5);
    @(negedge clk);
    oe_after = d_oe;
    #1;
    cs_n = 1'b1;
    tick(2);
  endtask

  task automatic inta_pulse(input logic [2:0] id, output logic [7:0] v, output logic oe);
    irq_id = id;
    tick(1);
    inta_n = 1'b0;
    tick(5);
    @(negedge clk);
    v = d_out; oe = d_oe;
    @(posedge clk); #1;
    inta_n = 1'b1;
    tick(6);
  endtask

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_INTA} op_e;
  typedef struct {
    op_e        op;
    logic       a;
    logic [7:0] d;
    logic [7:0] irr_v;
    logic [7:0] isr_v;
    logic [2:0] irq;
    logic [7:0] exp_d;
    logic       exp_oe;
    logic       exp_init;
  } vec_t;

  vec_t tbl[16];

  task automatic run_vec(input int i);
    logic [7:0] v;
    logic oe, oe_after;
    vec_t t;
    t = tbl[i];
    case (t.op)
      OP_WR: begin
        bus_write(t.a, t.d);
        check($sformatf("vec%0d init_done", i), int'(init_done), int'(t.exp_init));
      end
      OP_RD: begin
        irr = t.irr_v; isr = t.isr_v;
        bus_read(t.a, v, oe, oe_after);
        check($sformatf("vec%0d rd d_out", i), int'(v), int'(t.exp_d));
        check($sformatf("vec%0d rd d_oe", i), int'(oe), int'(t.exp_oe));
        check($sformatf("vec%0d rd d_oe after", i), int'(oe_after), 0);
      end
      default: begin
        inta_pulse(t.irq, v, oe);
        check($sformatf("vec%0d inta d_oe", i), int'(oe), int'(t.exp_oe));
        if (t.exp_oe) check($sformatf("vec%0d inta d_out", i), int'(v), int'(t.exp_d));
      end
    endcase
  endtask

  // Reference model state for the random phase
  logic [7:0] m_imr, m_vec, m_icw3, m_ocw2;
  logic       m_sel, m_upm, m_adi;
  logic [2:0] m_a75;
  int         m_stb;

  function automatic logic [7:0] exp_vec_byte(input int pulse, input logic [2:0] id);
    int b;
    if (m_upm) b = (pulse == 1) ? ((m_vec / 8) * 8 + id) : 0;
    else if (pulse == 0) b = 205;
    else if (pulse == 2) b = m_vec;
    else if (m_adi) b = m_a75 * 32 + id * 4;
    else b = (m_a75 / 2) * 64 + id * 8;
    return 8'(b);
  endfunction

  initial begin
    logic [7:0] v;
    logic oe, oe_after;
    int f0, l0, s0;

    tbl[0]  = '{OP_WR,   1'b0, 8'h13, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{OP_WR,   1'b1, 8'h40, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{OP_WR,   1'b1, 8'h01, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{OP_RD,   1'b0, 8'h00, 8'h5A, 8'h04, 3'd0, 8'h5A, 1'b1, 1'b1};
    tbl[4]  = '{OP_WR,   1'b1, 8'hA5, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{OP_RD,   1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 8'hA5, 1'b1, 1'b1};
    tbl[6]  = '{OP_WR,   1'b0, 8'h0B, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{OP_RD,   1'b0, 8'h00, 8'h81, 8'h04, 3'd0, 8'h04, 1'b1, 1'b1};
    tbl[8]  = '{OP_INTA, 1'b0, 8'h00, 8'h00, 8'h00, 3'd3, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{OP_INTA, 1'b0, 8'h00, 8'h00, 8'h00, 3'd6, 8'h43, 1'b1, 1'b1};
    tbl[10] = '{OP_WR,   1'b0, 8'h36, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{OP_WR,   1'b1, 8'h12, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{OP_INTA, 1'b0, 8'h00, 8'h00, 8'h00, 3'd5, 8'hCD, 1'b1, 1'b1};
    tbl[13] = '{OP_INTA, 1'b0, 8'h00, 8'h00, 8'h00, 3'd2, 8'h34, 1'b1, 1'b1};
    tbl[14] = '{OP_INTA, 1'b0, 8'h00, 8'h00, 8'h00, 3'd7, 8'h12, 1'b1, 1'b1};
    tbl[15] = '{OP_RD,   1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 1'b1, 1'b1};

    tick(3);
    check("reset init_done", int'(init_done), 0);
    check("reset d_oe", int'(d_oe), 0);
    check("reset d_out", int'(d_out), 0);
    check("reset imr", int'(imr), 0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 3; i++) run_vec(i);
    check("icw vec_hi", int'(vec_hi), 'h40);
    check("icw upm", int'(upm), 1);
    check("icw sngl", int'(sngl), 1);
    check("icw3 untouched", int'(icw3), 0);
    for (int i = 3; i < 8; i++) run_vec(i);
    f0 = first_cnt; l0 = last_cnt;
    run_vec(8);
    check("upm inta_first", first_cnt - f0, 1);
    check("upm no early last", last_cnt - l0, 0);
    run_vec(9);
    check("upm inta_last", last_cnt - l0, 1);
    for (int i = 10; i < 16; i++) run_vec(i);
    check("icw1 adi", int'(adi), 1);
    check("icw1 upm cleared", int'(upm), 0);
    check("8085 first count", first_cnt - f0, 2);
    check("8085 last count", last_cnt - l0, 2);

    // ICW1 while waiting for ICW3
    bus_write(1'b0, 8'h10);
    bus_write(1'b1, 8'h20);
    bus_write(1'b0, 8'h11);
    bus_write(1'b1, 8'h30);
    bus_write(1'b1, 8'h04);
    check("reinit w3 not ready", int'(init_done), 0);
    bus_write(1'b1, 8'h03);
    check("reinit ready", int'(init_done), 1);
    check("reinit vec", int'(vec_hi), 'h30);
    check("reinit icw3", int'(icw3), 'h04);
    check("reinit aeoi", int'(aeoi), 1);
    bus_write(1'b1, 8'hFF);
    check("ocw1 imr", int'(imr), 'hFF);

    // ICW1 between the pulses of an INTA sequence
    l0 = last_cnt;
    inta_pulse(3'd1, v, oe);
    bus_write(1'b0, 8'h13);
    check("abort init_done", int'(init_done), 0);
    check("abort imr", int'(imr), 0);
    bus_write(1'b1, 8'h48);
    bus_write(1'b1, 8'h01);
    inta_pulse(3'd2, v, oe);
    check("abort restart pulse1 oe", int'(oe), 0);
    inta_pulse(3'd0, v, oe);
    check("abort restart pulse2", int'(v), 'h4A);
    check("abort last count", last_cnt - l0, 1);

    // OCW2 strobe
    s0 = stb_cnt;
    bus_write(1'b0, 8'h20);
    check("ocw2 value", int'(ocw2), 'h20);
    check("ocw2 strobe", stb_cnt - s0, 1);

    // rd and wr overlapped with cs low
    bus_write(1'b1, 8'h5C);
    cs_n = 1'b0; a0 = 1'b1; d_in = 8'hC3;
    tick(1);
    rd_n = 1'b0; wr_n = 1'b0;
    tick(6);
    @(negedge clk);
    check("illegal d_oe", int'(d_oe), 0);
    #1;
    rd_n = 1'b1; wr_n = 1'b1;
    tick(6);
    cs_n = 1'b1;
    tick(2);
    check("illegal imr kept", int'(imr), 'h5C);

    // Async reset in the middle of a write
    cs_n = 1'b0; a0 = 1'b1; d_in = 8'h77;
    tick(1);
    wr_n = 1'b0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid init_done", int'(init_done), 0);
    check("rst mid imr", int'(imr), 0);
    check("rst mid vec_hi", int'(vec_hi), 0);
    check("rst mid upm", int'(upm), 0);
    check("rst mid d_oe", int'(d_oe), 0);
    wr_n = 1'b1; cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check("rst no late commit", int'(imr), 0);

    // Randomised traffic against the model
    m_imr = 0; m_vec = 0; m_icw3 = 0; m_ocw2 = 0; m_sel = 0; m_upm = 0; m_adi = 0; m_a75 = 0;
    m_stb = stb_cnt;
    for (int it = 0; it < 60; it++) begin
      int op;
      logic [7:0] r;
      op = (it == 0) ? 0 : int'($urandom_range(0, 5));
      r = 8'($urandom);
      case (op)
        0: begin
          logic ic4, sg;
          logic [7:0] w1, w4;
          ic4 = r[0]; sg = r[1];
          w1 = {r[7:5], 1'b1, r[3:2], sg, ic4};
          bus_write(1'b0, w1);
          m_a75 = r[7:5]; m_adi = r[2]; m_imr = 0; m_icw3 = 0; m_upm = 0; m_sel = 0;
          m_vec = 8'($urandom);
          bus_write(1'b1, m_vec);
          if (!sg) begin m_icw3 = 8'($urandom); bus_write(1'b1, m_icw3); end
          if (ic4) begin w4 = 8'($urandom); m_upm = w4[0]; bus_write(1'b1, w4); end
          check("rnd init_done", int'(init_done), 1);
          check("rnd vec_hi", int'(vec_hi), int'(m_vec));
          check("rnd icw3", int'(icw3), int'(m_icw3));
          check("rnd upm", int'(upm), int'(m_upm));
        end
        1: begin
          m_imr = r;
          bus_write(1'b1, r);
          check("rnd imr", int'(imr), int'(m_imr));
        end
        2: begin
          logic [7:0] w;
          w = {1'b0, r[6:5], 2'b01, r[2:0]};
          if (w[1]) m_sel = w[0];
          bus_write(1'b0, w);
        end
        3: begin
          logic [7:0] w;
          w = {r[7:5], 2'b00, r[2:0]};
          m_ocw2 = w; m_stb++;
          bus_write(1'b0, w);
          check("rnd ocw2", int'(ocw2), int'(m_ocw2));
          check("rnd ocw2 strobes", stb_cnt, m_stb);
        end
        4: begin
          logic a;
          logic [7:0] e;
          a = r[0];
          irr = 8'($urandom); isr = 8'($urandom);
          e = a ? m_imr : (m_sel ? isr : irr);
          bus_read(a, v, oe, oe_after);
          check("rnd read d_out", int'(v), int'(e));
          check("rnd read d_oe", int'(oe), 1);
          check("rnd read d_oe after", int'(oe_after), 0);
        end
        default: begin
          logic [2:0] id;
          int np;
          id = r[2:0];
          np = m_upm ? 2 : 3;
          l0 = last_cnt;
          for (int p = 0; p < np; p++) begin
            inta_pulse((p == 0) ? id : 3'($urandom), v, oe);
            if (m_upm && p == 0) check("rnd inta oe pulse1", int'(oe), 0);
            else begin
              check("rnd inta oe", int'(oe), 1);
              check("rnd inta byte", int'(v), int'(exp_vec_byte(p, id)));
            end
          end
          check("rnd inta_last", last_cnt - l0, 1);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pic_bus_rw_ctrl.md
Name: pic_bus_rw_ctrl

Overview:
Synchronous, parametrised successor to the PIC data-bus buffer and read/write control logic. It decodes CPU register accesses (ICW1–ICW4, OCW1–OCW3) with an initialisation-sequence FSM and returns IRR/ISR/IMR status on reads. It also sequences the INTA vector bytes for both 8086 (2-pulse) and MCS-80/85 (3-pulse CALL) modes. It sits between the external CPU bus pins and the priority resolver / in-service logic.

Parameters:
N_IRQ, 8, number of interrupt request lines (1..8); status reads are zero-extended to 8 bits
SYNC_STAGES, 2, synchroniser depth for rd_n, wr_n, inta_n, cs_n, a0

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
cs_n  input  1  chip select, active low
rd_n  input  1  read strobe, active low
wr_n  input  1  write strobe, active low
a0  input  1  register address bit
d_in  input  8  CPU data bus, input half
d_out  output  8  CPU data bus, output half
d_oe  output  1  drive enable for d_out
inta_n  input  1  interrupt acknowledge strobe, active low
irr  input  N_IRQ  interrupt request register, from the request block
isr  input  N_IRQ  in-service register, from the in-service block
irq_id  input  3  highest-priority request id, from the priority resolver
init_done  output  1  initialisation sequence complete
ltim, sngl, adi  output  1 each  ICW1 bits D3, D1, D2
vec_hi  output  8  ICW2
icw3  output  8  cascade mask / slave id
upm, aeoi, sfnm  output  1 each  ICW4 bits D0, D1, D4
imr  output  N_IRQ  interrupt mask (OCW1)
ocw2_stb  output  1  one-cycle strobe on an OCW2 write
ocw2  output  8  last OCW2 byte
inta_first  output  1  one-cycle pulse at the first INTA falling edge (freeze point)
inta_last  output  1  one-cycle pulse at the final INTA rising edge (end of sequence)

Behaviour:
- All strobes pass through SYNC_STAGES flops. Edges are detected on the synchronised copies. Latency from pin to action: SYNC_STAGES+1 cycles.
- Write commits on the synchronised wr_n rising edge, using cs_n, a0 and d_in captured at the wr_n falling edge. If cs_n was high at the falling edge, the write is ignored.
- rd_n and wr_n both low with cs_n low: illegal. No write is committed and d_oe=0.
- Init FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset state is UNINIT.
- ICW1 (a0=0, d[4]=1) is accepted in any state and restarts the sequence:
  - latches ltim/adi/sngl/ic4 and A7–A5 (d[7:5]);
  - clears imr and icw3;
  - sets upm=0, aeoi=0, sfnm=0, read-select to IRR;
  - aborts any INTA sequence in progress;
  - goes to WAIT_ICW2.
- WAIT_ICW2: an a0=1 write loads vec_hi. Next state is WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW3: an a0=1 write loads icw3. Next state is WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4: an a0=1 write loads upm, aeoi, sfnm. Next state is READY.
- In init states, a0=0 writes other than ICW1 are ignored.
- READY writes:
  - a0=1: imr <= d[N_IRQ-1:0].
  - a0=0 with d[4:3]=00: ocw2 <= d and a one-cycle ocw2_stb.
  - a0=0 with d[4:3]=01 (OCW3): if d[1]=1, read-select <= d[0] (0=IRR, 1=ISR); otherwise unchanged.
- init_done=1 only in READY.
- Reads:
  - On the synchronised rd_n falling edge with cs_n low: d_out <= a0 ? imr : (sel ? isr : irr), zero-extended. The value is snapshotted and held stable for the whole pulse.
  - d_oe=1 from the cycle after the falling edge until the synchronised rd_n rises.
  - Reads are allowed in any FSM state.
- INTA: ignored unless init_done=1. A 2-bit pulse counter advances on each synchronised inta_n rising edge.
  - upm=1 (2 pulses):
    - pulse 1: d_oe=0, inta_first asserted.
    - pulse 2: d_out = {vec_hi[7:3], irq_id}; inta_last asserted on its rise.
  - upm=0 (3 pulses):
    - pulse 1: d_out = 0xCD, inta_first asserted.
    - pulse 2: d_out = adi ? {A7–A5, irq_id, 2'b00} : {A7, A6, irq_id, 3'b000}.
    - pulse 3: d_out = vec_hi; inta_last asserted on its rise.
  - irq_id is sampled at inta_first and held for the rest of the sequence.
  - The counter returns to 0 after the last pulse.
  - d_oe=1 during driven pulses only.
- INTA takes priority over a concurrent rd_n for d_out/d_oe.
- Reset values: d_out=0, d_oe=0, init_done=0, imr=0, icw3=0, vec_hi=0, ocw2=0, all strobes 0, ltim=0, sngl=0, adi=0, upm=0, aeoi=0, sfnm=0, INTA counter=0. Reset mid-sequence returns the block to UNINIT immediately.

Decomposition:
- Shared package pic_pkg holds:
  - FSM state enum;
  - register-select constants;
  - CALL opcode 8'hCD;
  - ICW1/OCW decode bit positions.
- One natural sub-module, pic_strobe_sync: synchroniser plus rise/fall edge detector, instantiated per strobe.

Test Plan:
- ICW1=0x13 (sngl=1, ic4=1), ICW2=0x40, ICW4=0x01 -> init_done=1; vec_hi=0x40, upm=1; ICW3 state skipped.
- From READY: OCW1=0xA5, then read with a0=1 -> d_out=0xA5, d_oe=1 for the pulse; OCW3=0x0B, read with a0=0 and isr=0x04 -> d_out=0x04.
- upm=1, irq_id=3, two INTA pulses -> pulse 1 d_oe=0 with inta_first; pulse 2 d_out=0x43; inta_last on its rise.
- ICW1=0x36 (A7–A5=001, adi=1, sngl=1, ic4=0), ICW2=0x12, irq_id=5, three INTA pulses -> d_out 0xCD, 0x34, 0x12.
- ICW1 rewritten during WAIT_ICW3 and again mid-INTA -> FSM returns to WAIT_ICW2, imr=0, INTA counter=0, no inta_last.
- rd_n and wr_n low together with cs_n=0 -> no register change, d_oe=0; asynchronous reset mid-write -> all outputs at reset values, state UNINIT.
